// File: rtl/mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
// Shared types and constants for the mem_responder memory target.
//   mem_resp_state_t : response FSM state encoding
//   WORD_W           : data and address width in bits
//   MAX_WAIT         : largest supported WAIT_CYCLES value
//   CNT_W            : width of the wait-state counter
// -----------------------------------------------------------------------------
package mem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;

  localparam int WORD_W   = 32;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Request/ready handshake between an initiator (CPU memory port) and the
// mem_responder target.
//   Req      initiator -> target  request, sampled by the target only in IDLE
//   Wr       initiator -> target  1 = write, 0 = read
//   Address  initiator -> target  byte address
//   DataIn   initiator -> target  write data
//   DataOut  target -> initiator  read data, held until the next read response
//   Ready    target -> initiator  one-cycle completion pulse
//   Err      target -> initiator  misaligned-access flag, coincident with Ready
// Modports: master = initiator side, slave = target side.
// -----------------------------------------------------------------------------
interface mem_responder_if;
  import mem_resp_pkg::*;

  logic              Req;
  logic              Wr;
  logic [WORD_W-1:0] Address;
  logic [WORD_W-1:0] DataIn;
  logic [WORD_W-1:0] DataOut;
  logic              Ready;
  logic              Err;

  modport master (
    output Req, Wr, Address, DataIn,
    input  DataOut, Ready, Err
  );

  modport slave (
    input  Req, Wr, Address, DataIn,
    output DataOut, Ready, Err
  );

endinterface

// File: rtl/mem_resp_array.sv
// -----------------------------------------------------------------------------
// mem_resp_array
// Single-port word storage for mem_responder. Writes are synchronous; the read
// port is a plain lookup so the owner can register the word on exactly the
// edge it chooses (the response edge) and hold it afterwards.
//   Clk    in   clock, rising edge
//   we     in   write enable
//   idx    in   word index
//   wdata  in   write data
//   rdata  out  word currently stored at idx
// -----------------------------------------------------------------------------
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     Clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; contents must survive a reset and
  // a resettable array would force flops instead of RAM.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Word-addressed memory target with a request/ready handshake and
// WAIT_CYCLES programmable wait states. Owns the response FSM, the wait-state
// counter, the request capture registers and the storage array.
//   Clk    in     clock, rising edge
//   Reset  in     asynchronous active-low reset
//   bus    slave  Req/Wr/Address/DataIn in, DataOut/Ready/Err out
// Parameters: DEPTH (words, power of two >= 2), WAIT_CYCLES (0..15).
// Build option: MEM_RESP_ALIGN_CHECK_EN enables the misaligned-access check
// (Err with Ready, misaligned write dropped, misaligned read returns 0);
// without it Address[1:0] is ignored and Err stays 0.
// -----------------------------------------------------------------------------
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic            Clk,
  input logic            Reset,
  mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  mem_resp_state_t   state, nextState;
  logic [CNT_W-1:0]  cnt;

  logic              capWr, capMis;
  logic [IDX_W-1:0]  capIdx;
  logic [WORD_W-1:0] capData;

  logic              busMis;
  logic [IDX_W-1:0]  busIdx;

  logic              opWr, opMis;
  logic [IDX_W-1:0]  opIdx;
  logic [WORD_W-1:0] opData;

  logic              accept, enterResp, ramWe;
  logic [WORD_W-1:0] ramRdata;

  logic              readyQ, errQ;
  logic [WORD_W-1:0] dataOutQ;

  // Upper address bits alias modulo DEPTH*4.
  assign busIdx = bus.Address[IDX_W+1:2];

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign busMis = (bus.Address[1:0] != 2'b00);
  logic unusedAddrBits;
  assign unusedAddrBits = ^bus.Address[WORD_W-1:IDX_W+2];
`else
  assign busMis = 1'b0;
  logic unusedAddrBits;
  assign unusedAddrBits = ^{bus.Address[WORD_W-1:IDX_W+2], bus.Address[1:0]};
`endif

  assign accept = (state == IDLE) && bus.Req;

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (bus.Req) nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operation presented to the array. With WAIT_CYCLES=0 the response edge is
  // also the capture edge, so in IDLE the live bus request is used directly.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    opWr   = capWr;
    opMis  = capMis;
    opIdx  = capIdx;
    opData = capData;
    if (state == IDLE) begin
      opWr   = bus.Wr;
      opMis  = busMis;
      opIdx  = busIdx;
      opData = bus.DataIn;
    end
  end

  assign enterResp = (nextState == RESP);
  // Reset gates the write so a request presented during reset never lands.
  assign ramWe = enterResp && opWr && !opMis && Reset;

  // Capture registers, wait counter and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      capWr    <= 1'b0;
      capMis   <= 1'b0;
      capIdx   <= '0;
      capData  <= '0;
      cnt      <= '0;
      readyQ   <= 1'b0;
      errQ     <= 1'b0;
      dataOutQ <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (accept) begin
        capWr   <= bus.Wr;
        capMis  <= busMis;
        capIdx  <= busIdx;
        capData <= bus.DataIn;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      readyQ <= enterResp;
      errQ   <= enterResp && opMis;
      if (enterResp && !opWr) begin
        dataOutQ <= opMis ? '0 : ramRdata;
      end
    end
  end

  assign bus.Ready   = readyQ;
  assign bus.Err     = errQ;
  assign bus.DataOut = dataOutQ;

  mem_resp_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .Clk   (Clk),
    .we    (ramWe),
    .idx   (opIdx),
    .wdata (opData),
    .rdata (ramRdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Two responders share one clock and reset: a slow one (DEPTH 256, 2 wait
// states) and a fast one (DEPTH 16, no wait states). Expected values come from
// a word-array model per instance: index = byte address / 4 modulo DEPTH,
// Ready expected exactly WAIT_CYCLES edges after the capture edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int SLOW_DEPTH = 256;
  localparam int SLOW_WAIT  = 2;
  localparam int FAST_DEPTH = 16;
  localparam int FAST_WAIT  = 0;
`ifdef MEM_RESP_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mem_responder_if busSlow ();
  mem_responder_if busFast ();

  mem_responder #(.DEPTH(SLOW_DEPTH), .WAIT_CYCLES(SLOW_WAIT)) dutSlow (
    .Clk(Clk), .Reset(Reset), .bus(busSlow.slave)
  );
  mem_responder #(.DEPTH(FAST_DEPTH), .WAIT_CYCLES(FAST_WAIT)) dutFast (
    .Clk(Clk), .Reset(Reset), .bus(busFast.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] memSlow [int];
  logic [31:0] memFast [int];
  logic [31:0] lastOut [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit slow, input logic req, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (slow) begin
      busSlow.Req = req; busSlow.Wr = wr; busSlow.Address = addr; busSlow.DataIn = data;
    end else begin
      busFast.Req = req; busFast.Wr = wr; busFast.Address = addr; busFast.DataIn = data;
    end
  endtask

  function automatic logic getReady(input bit slow);
    return slow ? busSlow.Ready : busFast.Ready;
  endfunction

  function automatic logic getErr(input bit slow);
    return slow ? busSlow.Err : busFast.Err;
  endfunction

  function automatic logic [31:0] getData(input bit slow);
    return slow ? busSlow.DataOut : busFast.DataOut;
  endfunction

  // One complete transfer: Req presented for one capture edge, then dropped
  // with junk on the other inputs; Ready, Err and DataOut checked against the model.
  task automatic txn(input bit slow, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input string tag);
    int w, depth, idx;
    bit mis;
    logic [31:0] expOut;
    w     = slow ? SLOW_WAIT : FAST_WAIT;
    depth = slow ? SLOW_DEPTH : FAST_DEPTH;
    idx   = int'((addr >> 2) % 32'(depth));
    mis   = ALIGN && (addr[1:0] != 2'b00);
    if (wr) begin
      if (!mis) begin
        if (slow) memSlow[idx] = data; else memFast[idx] = data;
      end
      expOut = lastOut[int'(slow)];
    end else begin
      expOut = mis ? 32'h0 : (slow ? memSlow[idx] : memFast[idx]);
    end
    lastOut[int'(slow)] = expOut;

    @(negedge Clk);
    drive(slow, 1'b1, wr, addr, data);
    @(posedge Clk);
    #1;
    drive(slow, 1'b0, 1'($urandom), $urandom, $urandom);
    for (int k = 0; k <= w; k++) begin
      if (k > 0) begin
        @(posedge Clk);
        #1;
      end
      chk({tag, " ready"}, 32'(getReady(slow)), 32'(k == w));
    end
    chk({tag, " err"}, 32'(getErr(slow)), 32'(mis));
    chk({tag, " data"}, getData(slow), expOut);
    @(posedge Clk);
    #1;
    chk({tag, " ready drop"}, 32'(getReady(slow)), 32'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wrIdx[$];
    int idx;
    logic [31:0] addr, d, prior;

    lastOut[0] = '0;
    lastOut[1] = '0;
    Reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #12;
    chk("reset slow ready", 32'(busSlow.Ready), 32'h0);
    chk("reset slow err", 32'(busSlow.Err), 32'h0);
    chk("reset slow data", busSlow.DataOut, 32'h0);
    chk("reset fast ready", 32'(busFast.Ready), 32'h0);
    chk("reset fast data", busFast.DataOut, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;

    // T2: latency with two wait states, then read-back.
    txn(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, "t2 write");
    txn(1'b1, 1'b0, 32'h10, 32'h0, "t2 read");

    // T4: read with Req dropped right after capture.
    txn(1'b1, 1'b1, 32'h20, 32'h12345678, "t4 write");
    txn(1'b1, 1'b0, 32'h20, 32'h0, "t4 read");

    // T5: aliasing modulo DEPTH*4.
    txn(1'b1, 1'b1, 32'h404, 32'hA5A5A5A5, "t5 write");
    txn(1'b1, 1'b0, 32'h004, 32'h0, "t5 read");
    txn(1'b0, 1'b1, 32'h3C, 32'h0F0F0F0F, "t5 fast write");
    txn(1'b0, 1'b0, 32'h7C, 32'h0, "t5 fast alias read");

    // T6: misaligned write next to @0x10.
    txn(1'b1, 1'b1, 32'h10, 32'h11111111, "t6 base");
    txn(1'b1, 1'b1, 32'h13, 32'h22222222, "t6 misaligned write");
    txn(1'b1, 1'b0, 32'h10, 32'h0, "t6 readback");
    txn(1'b1, 1'b0, 32'h12, 32'h0, "t6 misaligned read");

    // T1: reset in the middle of a write's wait states.
    prior = $urandom;
    txn(1'b1, 1'b1, 32'hC, prior, "t1 prewrite");
    txn(1'b1, 1'b0, 32'h20, 32'h0, "t1 load dataout");
    @(negedge Clk);
    drive(1'b1, 1'b1, 1'b1, 32'hC, ~prior);
    @(posedge Clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("t1 reset ready", 32'(busSlow.Ready), 32'h0);
    chk("t1 reset err", 32'(busSlow.Err), 32'h0);
    chk("t1 reset data", busSlow.DataOut, 32'h0);
    lastOut[0] = '0;
    lastOut[1] = '0;
    @(negedge Clk);
    Reset = 1'b1;
    txn(1'b1, 1'b0, 32'hC, 32'h0, "t1 read prior");

    // Randomized writes on the slow responder, with aliasing upper bits.
    for (int i = 0; i < 12; i++) begin
      idx  = int'($urandom_range(SLOW_DEPTH - 1));
      addr = ($urandom & ~32'(SLOW_DEPTH * 4 - 1)) | (32'(idx) << 2);
      wrIdx.push_back(idx);
      txn(1'b1, 1'b1, addr, $urandom, "rand write");
    end
    // Randomized mixed traffic on written words, sometimes misaligned.
    for (int i = 0; i < 16; i++) begin
      idx  = wrIdx[$urandom_range(wrIdx.size() - 1)];
      addr = ($urandom & ~32'(SLOW_DEPTH * 4 - 1)) | (32'(idx) << 2)
             | 32'($urandom_range(3));
      txn(1'b1, 1'($urandom), addr, $urandom, "rand mixed");
    end

    // T3: fast responder, Req held high continuously.
    for (int i = 0; i < FAST_DEPTH; i++) begin
      txn(1'b0, 1'b1, 32'(i) << 2, $urandom, "t3 prewrite");
    end
    @(negedge Clk);
    for (int c = 0; c < 8; c++) begin
      d = $urandom;
      if (c % 2 == 0) begin
        idx = c / 2;
        memFast[idx] = d;
      end else begin
        idx = 8 + c;
      end
      drive(1'b0, 1'b1, 1'b1, 32'(idx) << 2, d);
      @(posedge Clk);
      #1;
      chk("t3 held ready", 32'(busFast.Ready), 32'(c % 2 == 0));
      chk("t3 held err", 32'(busFast.Err), 32'h0);
      chk("t3 held data", busFast.DataOut, lastOut[0]);
      @(negedge Clk);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < FAST_DEPTH; i++) begin
      txn(1'b0, 1'b0, 32'(i) << 2, 32'h0, "t3 readback");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
